// File: rtl/dwt_lift53_if.sv
// Sample-window / coefficient bus for the 5/3 lifting DWT stage.
// err is the sticky protocol-error flag, exported so a testbench can observe it.
interface dwt_lift53_if #(
  parameter int unsigned BW = 8,
  parameter int unsigned OW = BW + 2
);
  logic                 enable;
  logic                 clear;
  logic [3*BW-1:0]      win;
  logic                 win_valid;
  logic                 sol;
  logic                 eol;
  logic signed [OW-1:0] low;
  logic signed [OW-1:0] high;
  logic                 out_valid;
  logic                 out_last;
  logic                 busy;
  logic                 err;

  modport master (
    output enable, clear, win, win_valid, sol, eol,
    input  low, high, out_valid, out_last, busy, err
  );

  modport slave (
    input  enable, clear, win, win_valid, sol, eol,
    output low, high, out_valid, out_last, busy, err
  );
endinterface

// File: rtl/dwt_lift53.sv
// Two-stage LeGall 5/3 forward lifting: stage 1 predicts d[n], stage 2 updates s[n].
// Line edges use symmetric extension (x2e = x0 at eol, dp = d at line start).
module dwt_lift53 #(
  parameter int unsigned BW = 8,
  parameter int unsigned OW = BW + 2
) (
  input logic         i_clk,
  input logic         i_rst_n,
  dwt_lift53_if.slave io_bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e r_state, w_state_d;

  logic signed [OW-1:0] w_x0, w_x1, w_x2, w_x2e, w_sum, w_d;
  logic signed [OW-1:0] w_dp, w_s;
  logic signed [OW:0]   w_acc;
  logic                 w_line_open;

  logic signed [OW-1:0] r_d, r_x0, r_d_prev, r_low, r_high;
  logic                 r_sol1, r_eol1, r_v1;
  logic                 r_out_valid, r_out_last, r_err;

  // A line is open only in RUN and not once its eol pair sits in stage 1.
  assign w_line_open = (r_state == StRun) && !(r_v1 && r_eol1);

  // Stage 1: predict
  always_comb begin
    w_x0  = OW'(io_bus.win[BW-1:0]);
    w_x1  = OW'(io_bus.win[2*BW-1:BW]);
    w_x2  = OW'(io_bus.win[3*BW-1:2*BW]);
    w_x2e = io_bus.eol ? w_x0 : w_x2;
    w_sum = w_x0 + w_x2e;
    w_d   = w_x1 - (w_sum >>> 1);
  end

  // Stage 2: update; one guard bit keeps dp + d + 2 from wrapping when d is at its maximum.
  always_comb begin
    w_dp  = r_sol1 ? r_d : r_d_prev;
    w_acc = (OW+1)'(w_dp) + (OW+1)'(r_d) + (OW+1)'(2);
    w_s   = r_x0 + OW'(w_acc >>> 2);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_d         <= '0;
      r_x0        <= '0;
      r_sol1      <= 1'b0;
      r_eol1      <= 1'b0;
      r_v1        <= 1'b0;
      r_d_prev    <= '0;
      r_low       <= '0;
      r_high      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else if (io_bus.clear) begin
      r_v1        <= 1'b0;
      r_d_prev    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (io_bus.enable) begin
      r_v1 <= io_bus.win_valid;
      if (io_bus.win_valid) begin
        r_d    <= w_d;
        r_x0   <= w_x0;
        r_sol1 <= io_bus.sol || !w_line_open;
        r_eol1 <= io_bus.eol;
        r_err  <= r_err || (!io_bus.sol && !w_line_open);
      end
      r_out_valid <= r_v1;
      r_out_last  <= r_v1 && r_eol1;
      if (r_v1) begin
        r_low    <= w_s;
        r_high   <= r_d;
        r_d_prev <= r_d;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (io_bus.clear) begin
      w_state_d = StIdle;
    end else if (io_bus.enable) begin
      if (io_bus.win_valid) begin
        w_state_d = StRun;
      end else if (r_v1 && r_eol1) begin
        w_state_d = StIdle;
      end
    end
  end

  always_comb begin
    io_bus.busy      = (r_state == StRun);
    io_bus.low       = r_low;
    io_bus.high      = r_high;
    io_bus.out_valid = r_out_valid;
    io_bus.out_last  = r_out_last;
    io_bus.err       = r_err;
  end

endmodule

// File: tb/tb_dwt_lift53.sv
// Directed bench for dwt_lift53: a vector table streamed back-to-back, then stall,
// clear, protocol-error and asynchronous-reset sequences.
module tb_dwt_lift53;

  localparam int unsigned BW = 8;
  localparam int unsigned OW = 10;
  localparam int          NV = 10;

  typedef struct {
    logic [7:0] x0;
    logic [7:0] x1;
    logic [7:0] x2;
    logic       sol;
    logic       eol;
    int         low;
    int         high;
    int         last;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[NV];

  dwt_lift53_if #(.BW(BW), .OW(OW)) bus ();

  dwt_lift53 #(.BW(BW), .OW(OW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2,
                       input logic s, input logic e, input logic v);
    bus.win       = {x2, x1, x0};
    bus.sol       = s;
    bus.eol       = e;
    bus.win_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int v, input int lo, input int hi);
    check({tag, ".valid"}, int'(bus.out_valid), v);
    check({tag, ".low"}, int'(bus.low), lo);
    check({tag, ".high"}, int'(bus.high), hi);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // x0, x1, x2, sol, eol, low, high, last
    vecs[0] = '{8'd10,  8'd20,  8'd30,  1'b1, 1'b0, 10,  0,    0};
    vecs[1] = '{8'd30,  8'd40,  8'd50,  1'b0, 1'b0, 30,  0,    0};
    vecs[2] = '{8'd50,  8'd60,  8'd0,   1'b0, 1'b1, 53,  10,   1};
    vecs[3] = '{8'd255, 8'd0,   8'd255, 1'b1, 1'b0, 128, -255, 0};
    vecs[4] = '{8'd255, 8'd100, 8'd0,   1'b0, 1'b0, 185, -27,  0};
    vecs[5] = '{8'd0,   8'd200, 8'd0,   1'b0, 1'b1, 43,  200,  1};
    vecs[6] = '{8'd7,   8'd3,   8'd99,  1'b1, 1'b1, 5,   -4,   1};
    vecs[7] = '{8'd1,   8'd0,   8'd2,   1'b1, 1'b0, 1,   -1,   0};
    vecs[8] = '{8'd2,   8'd255, 8'd0,   1'b0, 1'b1, 65,  253,  1};
    vecs[9] = '{8'd0,   8'd255, 8'd0,   1'b1, 1'b1, 128, 255,  1};

    rst_n      = 1'b0;
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_out("rst", 0, 0, 0);
    check("rst.last", int'(bus.out_last), 0);
    check("rst.busy", int'(bus.busy), 0);
    check("rst.err", int'(bus.err), 0);
    step();
    step();
    rst_n      = 1'b1;
    bus.enable = 1'b1;

    // Back-to-back stream: output for window i is visible two edges after it is driven.
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) begin
        check_out($sformatf("vec%0d", i - 2), 1, vecs[i-2].low, vecs[i-2].high);
        check($sformatf("vec%0d.last", i - 2), int'(bus.out_last), vecs[i-2].last);
      end else begin
        check($sformatf("fill%0d.valid", i), int'(bus.out_valid), 0);
      end
      if (i < NV) drive(vecs[i].x0, vecs[i].x1, vecs[i].x2, vecs[i].sol, vecs[i].eol, 1'b1);
      else        drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      step();
    end
    check("drain.busy", int'(bus.busy), 0);
    check("drain.err", int'(bus.err), 0);

    // Enable stall between a window and its result.
    drive(8'd10, 8'd20, 8'd30, 1'b1, 1'b0, 1'b1);
    step();
    bus.enable = 1'b0;
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_out($sformatf("stall%0d", k), 0, 128, 255);
    end
    bus.enable = 1'b1;
    step();
    check_out("stall.out", 1, 10, 0);
    bus.enable = 1'b0;
    step();
    check_out("stall.hold", 1, 10, 0);
    bus.enable = 1'b1;
    step();
    check("stall.drop", int'(bus.out_valid), 0);

    // Clear right after a window, with another window offered during the clear.
    drive(8'd255, 8'd0, 8'd255, 1'b1, 1'b0, 1'b1);
    step();
    bus.clear = 1'b1;
    drive(8'd30, 8'd40, 8'd50, 1'b1, 1'b0, 1'b1);
    step();
    check_out("clr0", 0, 10, 0);
    check("clr0.busy", int'(bus.busy), 0);
    bus.clear = 1'b0;
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("clr1.valid", int'(bus.out_valid), 0);
    step();
    check("clr2.valid", int'(bus.out_valid), 0);
    drive(8'd30, 8'd40, 8'd50, 1'b1, 1'b0, 1'b1);
    step();
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("clr.after", 1, 30, 0);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;

    // Window without sol while idle: handled as a line start, raises err.
    check("err.pre", int'(bus.err), 0);
    drive(8'd1, 8'd0, 8'd2, 1'b0, 1'b0, 1'b1);
    step();
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("nosol", 1, 1, -1);
    check("nosol.err", int'(bus.err), 1);
    check("nosol.busy", int'(bus.busy), 1);

    // Asynchronous reset in the middle of a clock period with a window in flight.
    drive(8'd50, 8'd60, 8'd0, 1'b1, 1'b0, 1'b1);
    step();
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("arst", 0, 0, 0);
    check("arst.last", int'(bus.out_last), 0);
    check("arst.busy", int'(bus.busy), 0);
    check("arst.err", int'(bus.err), 0);
    step();
    rst_n = 1'b1;
    step();
    check("arst.rel0", int'(bus.out_valid), 0);
    step();
    check("arst.rel1", int'(bus.out_valid), 0);
    drive(8'd10, 8'd20, 8'd30, 1'b1, 1'b0, 1'b1);
    step();
    drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_out("arst.first", 1, 10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dwt_lift53.md
DWT_LIFT53 -- requirements
Module: dwt_lift53

Interface
REQ-001 Parameter BW, default 8: unsigned input sample width in bits.
REQ-002 Parameter OW, default BW+2: signed two's-complement width of each output coefficient.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately.
REQ-005 enable  input  1  high = pipeline advances; low = all registers hold.
REQ-006 clear  input  1  synchronous line flush; overrides enable.
REQ-007 win  input  3*BW  sample window: x0=win[BW-1:0]=x[2n], x1=win[2BW-1:BW]=x[2n+1], x2=win[3BW-1:2BW]=x[2n+2].
REQ-008 win_valid  input  1  single-cycle strobe, one per new window; sampled only when enable is high.
REQ-009 sol  input  1  qualifies win_valid: window is the first pair of the line.
REQ-010 eol  input  1  qualifies win_valid: window is the last pair of the line; x2 is invalid.
REQ-011 low  output  OW  low-pass coefficient s[n], registered.
REQ-012 high  output  OW  high-pass coefficient d[n], registered.
REQ-013 out_valid  output  1  one-cycle pulse when low/high update.
REQ-014 out_last  output  1  high with out_valid for the eol pair.
REQ-015 busy  output  1  high while the state is RUN.

Function
REQ-016 All arithmetic SHALL be signed at OW bits, with samples zero-extended from BW bits.
REQ-017 Stage 1 SHALL compute d = x1 - floor((x0 + x2e)/2), using an arithmetic right shift.
- x2e = x0 when eol=1 (symmetric extension); otherwise x2e = x2.
REQ-018 Stage 1 SHALL register d, x0, sol and eol, and set v1 on an enabled win_valid.
REQ-019 Stage 2 SHALL compute s = x0 + floor((dp + d + 2)/4), using an arithmetic right shift.
- dp = d when the registered sol=1; otherwise dp = d_prev.
REQ-020 Stage 2 SHALL, when v1 and enable, drive low=s and high=d, pulse out_valid, and load d_prev <= d.
- out_last SHALL equal the registered eol.
REQ-021 Latency: out_valid SHALL assert exactly 2 enabled cycles after the enabled win_valid.
- Throughput: one window per cycle.
REQ-022 While enable is low, no register SHALL change and out_valid SHALL hold at its current value.
REQ-023 State machine:
- IDLE -> RUN on an enabled win_valid with sol=1.
- RUN -> IDLE when the eol pair leaves stage 2.
- RUN -> RUN on other windows.
REQ-024 In IDLE, a win_valid with sol=0 SHALL still be processed as a line start (dp=d).
- That window SHALL also set the sticky flag err, observable only in verification.
REQ-025 sol=1 and eol=1 in the same window (a 2-sample line) SHALL use both extensions.
- Result: s = x0 + floor((2d+2)/4); the state returns to IDLE.
REQ-026 A win_valid with sol=1 arriving in RUN SHALL restart the line: dp=d and the state stays RUN.
REQ-027 clear=1 SHALL, on the next edge, do all of the following:
- zero v1, d_prev, out_valid and out_last;
- set the state to IDLE;
- leave low/high at their held values;
- discard any win_valid presented in the same cycle.
REQ-028 An eol window and a new sol window on consecutive cycles SHALL both be processed with no bubble.
- The sol window SHALL NOT use the old d_prev.
REQ-029 low and high SHALL NOT overflow for any BW-bit input when OW >= BW+2.

Reset
REQ-030 While reset is low, the block SHALL hold:
- low, high, d_prev and stage-1 registers at 0;
- out_valid, out_last, v1, busy and err at 0;
- the state at IDLE.
REQ-031 Outputs SHALL first change only on the first enabled clock edge after reset deasserts.
REQ-032 Reset asserted mid-line SHALL discard in-flight windows; no out_valid SHALL follow release without a new win_valid.

Verification
REQ-033 BW=8, single window sol=1, eol=0, x0=10, x1=20, x2=30, enable=1:
- 2 cycles later out_valid=1, high=0, low=10.
REQ-034 Line of three pairs:
- window 1: x=(10,20,30), sol=1 -> high=0, low=10;
- window 2: x=(30,40,50), dp=0 -> high=0, low=30;
- window 3: x=(50,60,–), eol=1, x2e=50 -> high=10, low=50+floor(12/4)=53, out_last=1, then busy=0.
REQ-035 Window x0=255, x1=0, x2=255, sol=1:
- high=-255, low=255+floor(-508/4)=128;
- confirms signed width and arithmetic shift.
REQ-036 Drop enable for 3 cycles between win_valid and its output:
- out_valid SHALL assert only after 2 enabled cycles;
- outputs SHALL be unchanged during the stall.
REQ-037 Assert clear the cycle after a win_valid:
- no out_valid SHALL follow;
- the next sol window SHALL produce the correct first-pair result.
REQ-038 Pull reset low asynchronously mid-clock during a line:
- all outputs SHALL go to 0 immediately;
- after release, a sol window SHALL match the REQ-033 result.
